// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus master.
//   mb_state_e    : FSM state encoding (IDLE/BUSY/HOLD)
//   STOP/NO_STOP  : stall request levels toward ctrl.stall_from_mem
//   ZERO_WORD     : 32-bit zero used for idle data paths
//   STALL_MEM_BIT : position of the MEM-stage hold bit in the ctrl stall vector
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    MB_IDLE = 2'b00,
    MB_BUSY = 2'b01,
    MB_HOLD = 2'b10
  } mb_state_e;

  localparam logic        STOP          = 1'b1;
  localparam logic        NO_STOP       = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam int          STALL_MEM_BIT = 4;

endpackage

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-bus master: turns a MEM-stage load/store into a
// Wishbone-classic cycle, stalls the pipeline until the access completes,
// and holds the load data stable until the MEM stage is released.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access; a new request launches a bus cycle
// BUSY  | CYC/STB asserted, waiting for ACK or timeout
// HOLD  | access done, rd_buf presented until MEM stage moves on
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   stall_i[5:0]      ctrl stall vector, bit 4 = MEM stage held
//   flush_i           pipeline flush, drops the current access
//   mem_req_i/we/addr/sel/wdata   MEM-stage access request
//   mem_rdata_o       load data (valid in HOLD only)
//   stall_req_o       pipeline stall request while access incomplete
//   bus_err_o         one-cycle pulse on timeout abort
//   bus_*_o           registered Wishbone master outputs
//   bus_rdata_i, bus_ack_i        Wishbone slave response
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_req_o,
  output logic        bus_err_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

  mb_state_e        state;
  logic [CNT_W-1:0] counter;
  logic             flushed;
  logic [31:0]      rd_buf;
  logic             access_done;

  // Only the MEM-stage bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  // Ack takes priority over a coincident timeout.
  assign access_done = bus_ack_i || (counter == CNT_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MB_IDLE;
      counter     <= '0;
      flushed     <= 1'b0;
      rd_buf      <= ZERO_WORD;
      bus_err_o   <= 1'b0;
      bus_cyc_o   <= 1'b0;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= ZERO_WORD;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= ZERO_WORD;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        MB_IDLE: begin
          if (mem_req_i && !flush_i) begin
            bus_cyc_o   <= 1'b1;
            bus_stb_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_sel_o   <= mem_sel_i;
            bus_wdata_o <= mem_wdata_i;
            counter     <= '0;
            state       <= MB_BUSY;
          end
        end
        MB_BUSY: begin
          counter <= counter + CNT_W'(1);
          if (flush_i) flushed <= 1'b1;
          if (access_done) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            rd_buf    <= (bus_ack_i && !bus_we_o) ? bus_rdata_i : ZERO_WORD;
            bus_err_o <= !bus_ack_i;
            flushed   <= 1'b0;
            // A flush landing on the completing cycle also kills the
            // instruction, so it must not reach HOLD either.
            state     <= (flushed || flush_i) ? MB_IDLE : MB_HOLD;
          end
        end
        MB_HOLD: begin
          if (!stall_i[STALL_MEM_BIT] || flush_i) state <= MB_IDLE;
        end
        default: state <= MB_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req_o = NO_STOP;
    mem_rdata_o = ZERO_WORD;
    case (state)
      MB_IDLE: if (mem_req_i && !flush_i) stall_req_o = STOP;
      MB_BUSY: stall_req_o = STOP;
      MB_HOLD: mem_rdata_o = rd_buf;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = 6'b0;
  logic        flush_i = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        stall_req_o;
  logic        bus_err_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  mem_bus_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .stall_req_o(stall_req_o), .bus_err_o(bus_err_o), .bus_cyc_o(bus_cyc_o),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: the access occupies min(ack_at, TIMEOUT)
  // BUSY cycles after the request cycle; ack_at > TIMEOUT means no ack.
  // flush_at (1-based BUSY cycle, 0 = none) diverts to IDLE instead of HOLD.
  // hold_n stalled HOLD cycles precede the releasing one.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_at, input int flush_at, input int hold_n,
                         input logic exit_by_flush);
    int  end_k;
    bit  timeout;
    bit  dropped;
    logic [31:0] exp_rd;
    end_k   = (ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
    timeout = (ack_at > TIMEOUT);
    dropped = (flush_at >= 1 && flush_at <= end_k);
    exp_rd  = (!we && !timeout) ? rdata : 32'h0;

    // request cycle (IDLE); a stray ack here must be ignored
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel;
    mem_wdata_i = wdata; flush_i = 1'b0; stall_i = 6'b011111;
    bus_ack_i = 1'($urandom_range(0, 1)); bus_rdata_i = $urandom;
    #1;
    chk("req_stall", stall_req_o, 1);
    chk("req_cyc", bus_cyc_o, 0);
    chk("req_rdata", mem_rdata_o, 0);

    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      mem_req_i = 1'($urandom_range(0, 1)); mem_we_i = 1'($urandom_range(0, 1));
      mem_addr_i = $urandom; mem_sel_i = 4'($urandom); mem_wdata_i = $urandom;
      bus_ack_i = (k == ack_at);
      bus_rdata_i = (k == ack_at) ? rdata : $urandom;
      flush_i = (k == flush_at);
      #1;
      chk("busy_stall", stall_req_o, 1);
      chk("busy_cyc", bus_cyc_o, 1);
      chk("busy_stb", bus_stb_o, 1);
      chk("busy_we", bus_we_o, we);
      chk("busy_addr", bus_addr_o, addr);
      chk("busy_sel", bus_sel_o, sel);
      chk("busy_wdata", bus_wdata_o, wdata);
      chk("busy_rdata", mem_rdata_o, 0);
      chk("busy_err", bus_err_o, 0);
    end

    if (dropped) begin
      @(negedge clk);
      bus_ack_i = 1'b0; flush_i = 1'b0; mem_req_i = 1'b0; stall_i = 6'b011111;
      #1;
      chk("drop_stall", stall_req_o, 0);
      chk("drop_cyc", bus_cyc_o, 0);
      chk("drop_stb", bus_stb_o, 0);
      chk("drop_err", bus_err_o, timeout);
      chk("drop_rdata", mem_rdata_o, 0);
    end else begin
      for (int h = 0; h <= hold_n; h++) begin
        @(negedge clk);
        flush_i = 1'b0;
        mem_req_i = 1'b1;
        bus_ack_i = 1'($urandom_range(0, 1)); bus_rdata_i = $urandom;
        if (h == hold_n) begin
          if (exit_by_flush) flush_i = 1'b1;
          else stall_i = 6'b000000;
        end
        #1;
        chk("hold_stall", stall_req_o, 0);
        chk("hold_cyc", bus_cyc_o, 0);
        chk("hold_err", bus_err_o, (h == 0) ? timeout : 1'b0);
        chk("hold_rdata", mem_rdata_o, exp_rd);
      end
    end
    @(negedge clk);
    mem_req_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; stall_i = 6'b000000;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall_req_o, 0);
    chk("rst_cyc", bus_cyc_o, 0);
    chk("rst_stb", bus_stb_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    rst = 1'b0;

    // directed: minimal load, 5-cycle store, timeout, flush mid-busy, long HOLD
    run_txn(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678, 32'hCAFE_F00D, 5, 0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0200, 4'b1111, 32'h0, 32'h5555_AAAA, 100, 0, 1, 1'b0);
    run_txn(1'b0, 32'h0000_0300, 4'b1111, 32'h0, 32'h1111_2222, 4, 2, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0400, 4'b1100, 32'h0, 32'hA5A5_5A5A, 2, 0, 3, 1'b0);
    // ack coincident with the timeout cycle: ack wins
    run_txn(1'b0, 32'h0000_0500, 4'b0001, 32'h0, 32'h0BAD_CAFE, TIMEOUT, 0, 0, 1'b0);
    // flush releases HOLD
    run_txn(1'b0, 32'h0000_0600, 4'b1111, 32'h0, 32'h7777_8888, 3, 0, 2, 1'b1);

    // asynchronous reset in the middle of BUSY
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0700; mem_sel_i = 4'hF;
    repeat (3) begin
      @(negedge clk);
      mem_req_i = 1'b0;
    end
    #1;
    chk("pre_rst_cyc", bus_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cyc", bus_cyc_o, 0);
    chk("async_rst_stb", bus_stb_o, 0);
    chk("async_rst_stall", stall_req_o, 0);
    @(negedge clk);
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_0000;
    #1;
    chk("late_ack_cyc", bus_cyc_o, 0);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk("late_ack_stall", stall_req_o, 0);
    chk("late_ack_err", bus_err_o, 0);
    chk("late_ack_rdata", mem_rdata_o, 0);

    // randomized accesses
    for (int t = 0; t < 40; t++) begin
      int ack_at;
      int flush_at;
      ack_at   = $urandom_range(1, TIMEOUT + 4);
      flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT) : 0;
      run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
              ack_at, flush_at, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
